mac_rx_crc_verify: RTL and testbench

- Ethernet MAC receive front end.
- Takes GMII-style bytes in the PHY receive clock domain, strips the preamble and SFD, checks the FCS (CRC-32) and removes it from the stream.
- Hands the frame payload (destination MAC through end of payload) to the logic clock domain as a byte-wide AXI-Stream.
- On the last beat, tuser flags frames with a bad CRC, a PHY error or an overflow.

---
 rtl/mac_pkg.sv | 41 ++++
 rtl/mac_rx_crc_verify_async_fifo.sv | 83 ++++++++
 rtl/mac_rx_crc_verify.sv | 156 +++++++++++++++
 tb/tb_mac_rx_crc_verify.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants, types and the byte-wide CRC-32 step for the MAC receive path.
package mac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam int          DLY_LEN       = 5;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // LSB-first engine shifts right, so it needs the bit-reversed polynomial.
  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_PREAMBLE,
    RX_DATA,
    RX_END,
    RX_DROP
  } rx_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } fifo_entry_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/mac_rx_crc_verify_async_fifo.sv
// Dual-clock FIFO with Gray-coded pointers and first-word fall-through read.
// almost_full is raised once fewer than two entries are free.
module async_fifo #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 10
) (
  input  logic             wr_clk,
  input  logic             wr_rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             almost_full,
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_bin, wr_bin_nxt, wr_gray;
  logic [AW:0] rd_bin, rd_bin_nxt, rd_gray;
  logic [AW:0] rd_gray_m, rd_gray_s, wr_gray_m, wr_gray_s;
  logic [AW:0] rd_bin_s, used;
  logic        full, wr_do, rd_do;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Occupancy seen from the write side is pessimistic, which is the safe direction.
  assign rd_bin_s    = gray2bin(rd_gray_s);
  assign used        = wr_bin - rd_bin_s;
  assign full        = used[AW];
  assign almost_full = (used >= (AW+1)'(DEPTH - 1));
  assign wr_do       = wr_en & ~full;
  assign wr_bin_nxt  = wr_bin + (AW+1)'(1);

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_bin    <= '0;
      wr_gray   <= '0;
      rd_gray_m <= '0;
      rd_gray_s <= '0;
    end else begin
      rd_gray_m <= rd_gray;
      rd_gray_s <= rd_gray_m;
      if (wr_do) begin
        wr_bin  <= wr_bin_nxt;
        wr_gray <= wr_bin_nxt ^ (wr_bin_nxt >> 1);
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_do) mem[wr_bin[AW-1:0]] <= wr_data;
  end

  assign empty      = (rd_gray == wr_gray_s);
  assign rd_do      = rd_en & ~empty;
  assign rd_bin_nxt = rd_bin + (AW+1)'(1);
  assign rd_data    = mem[rd_bin[AW-1:0]];

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin    <= '0;
      rd_gray   <= '0;
      wr_gray_m <= '0;
      wr_gray_s <= '0;
    end else begin
      wr_gray_m <= wr_gray;
      wr_gray_s <= wr_gray_m;
      if (rd_do) begin
        rd_bin  <= rd_bin_nxt;
        rd_gray <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
      end
    end
  end

endmodule

// File: rtl/mac_rx_crc_verify.sv
// GMII receive front end: strips preamble/SFD, checks and removes the FCS,
// and delivers the frame as byte-wide AXI-Stream in the clk domain.
//
// state       | meaning
// RX_IDLE     | waiting for rvalid
// RX_PREAMBLE | consuming 0x55 bytes until the SFD
// RX_DATA     | frame bytes feed CRC and 5-byte delay line
// RX_END      | write last beat with bad flag, drop FCS
// RX_DROP     | discard a malformed frame until rvalid falls
module mac_rx_crc_verify
  import mac_pkg::*;
#(
  parameter int FIFO_DEPTH = 4096,
  parameter int MIN_FRAME  = 64
) (
  input  logic       clk,
  input  logic       logic_rst,
  input  logic       phy_rx_clk,
  input  logic [7:0] phy_rxd_in,
  input  logic       phy_rvalid_in,
  input  logic       phy_rerr_in,
  output logic [7:0] mac_data_out,
  output logic       mac_valid_out,
  input  logic       mac_ready_in,
  output logic       mac_last_out,
  output logic       mac_user_out
);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
  localparam logic [15:0] DLY_FULL = 16'(DLY_LEN);

  logic [1:0] phy_rst_sync, sys_rst_sync;
  logic       phy_rst, sys_rst;

  always_ff @(posedge phy_rx_clk or posedge logic_rst) begin
    if (logic_rst) phy_rst_sync <= 2'b11;
    else           phy_rst_sync <= {phy_rst_sync[0], 1'b0};
  end
  assign phy_rst = phy_rst_sync[1];

  always_ff @(posedge clk or posedge logic_rst) begin
    if (logic_rst) sys_rst_sync <= 2'b11;
    else           sys_rst_sync <= {sys_rst_sync[0], 1'b0};
  end
  assign sys_rst = sys_rst_sync[1];

  logic [7:0] rxd_q;
  logic       rv_q, rerr_q;

  always_ff @(posedge phy_rx_clk or posedge phy_rst) begin
    if (phy_rst) begin
      rxd_q  <= '0;
      rv_q   <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      rxd_q  <= phy_rxd_in;
      rv_q   <= phy_rvalid_in;
      rerr_q <= phy_rerr_in;
    end
  end

  rx_state_t              state, state_nxt;
  logic [31:0]            crc;
  logic [15:0]            cnt;
  logic [DLY_LEN-1:0][7:0] dly;
  logic                   bad, dly_full, frame_bad, almost_full, wr_en;
  fifo_entry_t            wr_entry;

  assign dly_full  = (cnt >= DLY_FULL);
  assign frame_bad = bad | (crc != CRC_RESIDUE) | (cnt < MIN_LEN);

  always_comb begin
    state_nxt     = state;
    wr_en         = 1'b0;
    wr_entry.data = dly[DLY_LEN-1];
    wr_entry.last = 1'b0;
    wr_entry.user = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rv_q) begin
          if (rxd_q == PREAMBLE_BYTE) state_nxt = RX_PREAMBLE;
          else if (rxd_q == SFD_BYTE) state_nxt = RX_DATA;
          else                        state_nxt = RX_DROP;
        end
      end
      RX_PREAMBLE: begin
        if (!rv_q)                       state_nxt = RX_IDLE;
        else if (rxd_q == SFD_BYTE)      state_nxt = RX_DATA;
        else if (rxd_q != PREAMBLE_BYTE) state_nxt = RX_DROP;
      end
      RX_DATA: begin
        if (!rv_q) state_nxt = RX_END;
        else if (dly_full && !almost_full) wr_en = 1'b1;
      end
      RX_END: begin
        state_nxt = RX_IDLE;
        // The last beat always fits: non-last writes leave one entry in reserve.
        if (dly_full) begin
          wr_en         = 1'b1;
          wr_entry.last = 1'b1;
          wr_entry.user = frame_bad;
        end
      end
      RX_DROP: begin
        if (!rv_q) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge phy_rx_clk or posedge phy_rst) begin
    if (phy_rst) begin
      state <= RX_IDLE;
      crc   <= CRC_INIT;
      cnt   <= '0;
      bad   <= 1'b0;
      dly   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == RX_DATA && state != RX_DATA) begin
        crc <= CRC_INIT;
        cnt <= '0;
        bad <= 1'b0;
      end else if (state == RX_DATA && rv_q) begin
        crc <= crc32_byte(crc, rxd_q);
        dly <= {dly[DLY_LEN-2:0], rxd_q};
        if (cnt != '1) cnt <= cnt + 16'd1;
        if (rerr_q || (dly_full && almost_full)) bad <= 1'b1;
      end
    end
  end

  fifo_entry_t head;
  logic        empty;

  async_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(fifo_entry_t))
  ) u_fifo (
    .wr_clk     (phy_rx_clk),
    .wr_rst     (phy_rst),
    .wr_en      (wr_en),
    .wr_data    (wr_entry),
    .almost_full(almost_full),
    .rd_clk     (clk),
    .rd_rst     (sys_rst),
    .rd_en      (mac_ready_in),
    .rd_data    (head),
    .empty      (empty)
  );

  assign mac_valid_out = ~empty;
  assign mac_data_out  = mac_valid_out ? head.data : 8'h00;
  assign mac_last_out  = mac_valid_out & head.last;
  assign mac_user_out  = mac_valid_out & head.last & head.user;

endmodule

// File: tb/tb_mac_rx_crc_verify.sv
// Directed bench for mac_rx_crc_verify: frames with bench-computed FCS and scoreboarded beats.
module tb_mac_rx_crc_verify;

  logic       clk = 1'b0;
  logic       phy_rx_clk = 1'b0;
  logic       logic_rst;
  logic [7:0] phy_rxd_in;
  logic       phy_rvalid_in;
  logic       phy_rerr_in;
  logic [7:0] mac_data_out;
  logic       mac_valid_out;
  logic       mac_ready_in;
  logic       mac_last_out;
  logic       mac_user_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tx_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  bit         rand_ready = 1'b0;
  bit         ready_fixed = 1'b1;
  bit         stalled = 1'b0;
  logic [10:0] held;

  always #5 clk = ~clk;
  always #4 phy_rx_clk = ~phy_rx_clk;

  mac_rx_crc_verify #(.FIFO_DEPTH(4096), .MIN_FRAME(64)) dut (
    .clk          (clk),
    .logic_rst    (logic_rst),
    .phy_rx_clk   (phy_rx_clk),
    .phy_rxd_in   (phy_rxd_in),
    .phy_rvalid_in(phy_rvalid_in),
    .phy_rerr_in  (phy_rerr_in),
    .mac_data_out (mac_data_out),
    .mac_valid_out(mac_valid_out),
    .mac_ready_in (mac_ready_in),
    .mac_last_out (mac_last_out),
    .mac_user_out (mac_user_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit-serial reflected CRC-32 used to build the transmitted FCS.
  function automatic logic [31:0] tb_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int j = 0; j < 8; j++) begin
      fb = r[0] ^ b[j];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Output sink: ready is changed on the falling edge, beats recorded for the next rising edge.
  initial begin
    mac_ready_in = 1'b1;
    forever begin
      @(negedge clk);
      mac_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
      if (stalled && !logic_rst)
        chk("hold", {21'h0, mac_valid_out, mac_data_out, mac_last_out, mac_user_out}, {21'h0, held});
      if (mac_valid_out && mac_ready_in)
        got_q.push_back({mac_data_out, mac_last_out, mac_user_out});
      stalled = mac_valid_out && !mac_ready_in && !logic_rst;
      held    = {mac_valid_out, mac_data_out, mac_last_out, mac_user_out};
    end
  end

  task automatic build_frame(input int n_pay, input int seed, input bit bad_fcs,
                             input bit bad_pre, input bit exp_out, input bit exp_bad);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    tx_q.delete();
    for (int i = 0; i < 7; i++) tx_q.push_back(8'h55);
    if (bad_pre) tx_q[1] = 8'h54;
    tx_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_pay; i++) begin
      b = 8'(seed * 13 + i * 7 + 1);
      tx_q.push_back(b);
      c = tb_crc(c, b);
      if (exp_out) exp_q.push_back({b, (i == n_pay - 1), (i == n_pay - 1) && exp_bad});
    end
    fcs = ~c;
    tx_q.push_back(fcs[7:0]);
    tx_q.push_back(fcs[15:8]);
    tx_q.push_back(fcs[23:16]);
    tx_q.push_back(fcs[31:24] ^ {7'h0, bad_fcs});
  endtask

  task automatic send(input int n_bytes, input int err_idx, input int gap);
    for (int i = 0; i < n_bytes && i < tx_q.size(); i++) begin
      @(negedge phy_rx_clk);
      phy_rxd_in    = tx_q[i];
      phy_rvalid_in = 1'b1;
      phy_rerr_in   = (i == err_idx);
    end
    @(negedge phy_rx_clk);
    phy_rxd_in    = 8'h00;
    phy_rvalid_in = 1'b0;
    phy_rerr_in   = 1'b0;
    repeat (gap) @(negedge phy_rx_clk);
  endtask

  task automatic verify(input string tag);
    int c;
    c = 0;
    while (got_q.size() < exp_q.size() && c < 20000) begin
      @(posedge clk);
      c++;
    end
    repeat (50) @(posedge clk);
    chk({tag, "_beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < got_q.size()) ? {22'h0, got_q[i]} : 32'hFFFFFFFF, {22'h0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, mac_valid_out, 1'b0);
    chk({tag, "_last"}, mac_last_out, 1'b0);
    chk({tag, "_user"}, mac_user_out, 1'b0);
    chk({tag, "_data"}, mac_data_out, 8'h00);
  endtask

  initial begin
    logic_rst     = 1'b1;
    phy_rxd_in    = 8'h00;
    phy_rvalid_in = 1'b0;
    phy_rerr_in   = 1'b0;
    repeat (5) @(posedge clk);
    chk_idle("reset");
    logic_rst = 1'b0;
    repeat (10) @(posedge clk);

    build_frame(60, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    send(tx_q.size(), -1, 19);
    verify("good");

    build_frame(60, 2, 1'b1, 1'b0, 1'b1, 1'b1);
    send(tx_q.size(), -1, 19);
    verify("bad_fcs");

    // Payload byte 32 sits after 7 preamble bytes and the SFD.
    build_frame(60, 3, 1'b0, 1'b0, 1'b1, 1'b1);
    send(tx_q.size(), 8 + 31, 19);
    verify("rerr");
    build_frame(60, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    send(tx_q.size(), -1, 19);
    verify("after_rerr");

    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      build_frame(68, 10 + f, 1'b0, 1'b0, 1'b1, 1'b0);
      send(tx_q.size(), -1, 19);
    end
    verify("b2b");
    rand_ready = 1'b0;

    build_frame(20, 5, 1'b0, 1'b0, 1'b1, 1'b1);
    send(tx_q.size(), -1, 19);
    verify("runt");

    build_frame(60, 6, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8 + 3, -1, 19);
    verify("tiny");

    build_frame(60, 7, 1'b0, 1'b1, 1'b0, 1'b0);
    send(tx_q.size(), -1, 19);
    verify("bad_pre");

    // Hold the sink off so partial-frame beats are still queued when reset hits.
    ready_fixed = 1'b0;
    build_frame(60, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8 + 30; i++) begin
      @(negedge phy_rx_clk);
      phy_rxd_in    = tx_q[i];
      phy_rvalid_in = 1'b1;
    end
    repeat (20) @(posedge clk);
    logic_rst = 1'b1;
    @(negedge phy_rx_clk);
    phy_rvalid_in = 1'b0;
    phy_rxd_in    = 8'h00;
    repeat (3) @(posedge clk);
    chk_idle("rst_mid");
    logic_rst = 1'b0;
    repeat (10) @(posedge clk);
    ready_fixed = 1'b1;
    verify("rst_flush");
    build_frame(60, 9, 1'b0, 1'b0, 1'b1, 1'b0);
    send(tx_q.size(), -1, 19);
    verify("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
